// File: rtl/gpioemu_mul_pkg.sv
// rtl/gpioemu_mul_pkg.sv - register map, status codes and FSM encodings for the multiplier scheduler
package gpioemu_mul_pkg;

  localparam int OPW = 24;

  localparam logic [15:0] ADDR_A1 = 16'h01D8;
  localparam logic [15:0] ADDR_A2 = 16'h01E0;
  localparam logic [15:0] ADDR_W  = 16'h01E8;
  localparam logic [15:0] ADDR_L  = 16'h01F0;
  localparam logic [15:0] ADDR_B  = 16'h01F8;

  localparam logic [31:0] ST_IDLE = 32'd0;
  localparam logic [31:0] ST_BUSY = 32'd1;
  localparam logic [31:0] ST_OVF  = 32'd2;

  typedef enum logic [3:0] {
    S_IDLE, S_GRANT, S_WR_A1, S_WR_A2, S_POLL, S_GAP, S_RD_W, S_RD_L, S_RESP
  } state_t;

  typedef enum logic [1:0] {PH_SETUP, PH_STROBE, PH_HOLD} phase_t;

endpackage

// File: rtl/gpioemu_rr_arb.sv
// rtl/gpioemu_rr_arb.sv - round-robin one-hot picker; pointer moves past the winner on take
module gpioemu_rr_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 3
) (
  input  logic            clk,
  input  logic            n_reset,
  input  logic [NREQ-1:0] req_i,
  input  logic            take_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  gnt_id_o,
  output logic            valid_o
);

  logic [IDW-1:0] ptr_q;

  // First pass covers requesters at or after the pointer, second pass wraps around.
  always_comb begin
    gnt_o    = '0;
    gnt_id_o = '0;
    valid_o  = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (!valid_o && req_i[j] && (j >= int'(ptr_q))) begin
        valid_o  = 1'b1;
        gnt_o[j] = 1'b1;
        gnt_id_o = IDW'(j);
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (!valid_o && req_i[j]) begin
        valid_o  = 1'b1;
        gnt_o[j] = 1'b1;
        gnt_id_o = IDW'(j);
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      ptr_q <= '0;
    end else if (take_i && valid_o) begin
      ptr_q <= (gnt_id_o == IDW'(NREQ - 1)) ? '0 : gnt_id_o + 1'b1;
    end
  end

endmodule

// File: rtl/gpioemu_mul_sched.sv
// rtl/gpioemu_mul_sched.sv - shares the bus-mapped multiplier between requesters, sequencing its register protocol
// MUL_TIMEOUT_EN: bounds status polling to POLL_LIMIT polls, aborting the job with rsp_err.
module gpioemu_mul_sched
  import gpioemu_mul_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 3,
`ifdef MUL_TIMEOUT_EN
  parameter int POLL_LIMIT = 1023,
`endif
  parameter int POLL_GAP = 4
) (
  input  logic                clk,
  input  logic                n_reset,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*OPW-1:0] op_a,
  input  logic [NREQ*OPW-1:0] op_b,
  output logic [NREQ-1:0]     ack,
  output logic                rsp_valid,
  output logic [IDW-1:0]      rsp_id,
  output logic [31:0]         rsp_w,
  output logic [31:0]         rsp_ones,
  output logic                rsp_ovf,
  output logic                rsp_err,
  output logic                busy,
  output logic [15:0]         m_saddress,
  output logic                m_swr,
  output logic                m_srd,
  output logic [31:0]         m_wdata,
  input  logic [31:0]         m_rdata
);

  state_t          state_q;
  phase_t          ph_q;
  logic [NREQ-1:0] ack_q;
  logic            rsp_valid_q, rsp_ovf_q, rsp_err_q, busy_q;
  logic [IDW-1:0]  rsp_id_q;
  logic [31:0]     rsp_w_q, rsp_ones_q, wdata_q, w_q;
  logic [15:0]     addr_q;
  logic            swr_q, srd_q, ovf_q, err_q;
  logic [OPW-1:0]  a_q, b_q;
  logic [7:0]      gap_q;
`ifdef MUL_TIMEOUT_EN
  logic [9:0]      poll_q;
`endif

  logic [NREQ-1:0] arb_gnt;
  logic [IDW-1:0]  arb_id;
  logic            arb_valid, is_wr;

  assign is_wr = (state_q == S_WR_A1) || (state_q == S_WR_A2);

  gpioemu_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .clk      (clk),
    .n_reset  (n_reset),
    .req_i    (req),
    .take_i   (state_q == S_IDLE),
    .gnt_o    (arb_gnt),
    .gnt_id_o (arb_id),
    .valid_o  (arb_valid)
  );

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= S_IDLE;
      ph_q        <= PH_SETUP;
      ack_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_w_q     <= '0;
      rsp_ones_q  <= '0;
      rsp_ovf_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      swr_q       <= 1'b0;
      srd_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      w_q         <= '0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      gap_q       <= '0;
`ifdef MUL_TIMEOUT_EN
      poll_q      <= '0;
`endif
    end else begin
      ack_q       <= '0;
      rsp_valid_q <= 1'b0;
      swr_q       <= 1'b0;
      srd_q       <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (arb_valid) begin
            ack_q    <= arb_gnt;
            rsp_id_q <= arb_id;
            busy_q   <= 1'b1;
            state_q  <= S_GRANT;
            for (int k = 0; k < NREQ; k++) begin
              if (arb_gnt[k]) begin
                a_q <= op_a[k*OPW +: OPW];
                b_q <= op_b[k*OPW +: OPW];
              end
            end
          end
        end
        S_GRANT: begin
          addr_q  <= ADDR_A1;
          wdata_q <= {8'h00, a_q};
          ph_q    <= PH_SETUP;
          ovf_q   <= 1'b0;
          err_q   <= 1'b0;
`ifdef MUL_TIMEOUT_EN
          poll_q  <= '0;
`endif
          state_q <= S_WR_A1;
        end
        S_GAP: begin
          if (gap_q == 8'(POLL_GAP - 1)) state_q <= S_POLL;
          else                           gap_q   <= gap_q + 8'd1;
        end
        S_RESP: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        S_WR_A1, S_WR_A2, S_POLL, S_RD_W, S_RD_L: begin
          case (ph_q)
            PH_SETUP: begin
              ph_q  <= PH_STROBE;
              swr_q <= is_wr;
              srd_q <= ~is_wr;
            end
            PH_STROBE: ph_q <= PH_HOLD;
            default: begin
              // End of HOLD: consume read data and set up the next access.
              ph_q <= PH_SETUP;
              case (state_q)
                S_WR_A1: begin
                  addr_q  <= ADDR_A2;
                  wdata_q <= {8'h00, b_q};
                  state_q <= S_WR_A2;
                end
                S_WR_A2: begin
                  addr_q  <= ADDR_B;
                  wdata_q <= '0;
                  state_q <= S_POLL;
                end
                S_POLL: begin
                  if (m_rdata == ST_BUSY) begin
`ifdef MUL_TIMEOUT_EN
                    if (poll_q == 10'(POLL_LIMIT - 1)) begin
                      rsp_w_q     <= '0;
                      rsp_ones_q  <= '0;
                      rsp_ovf_q   <= 1'b0;
                      rsp_err_q   <= 1'b1;
                      rsp_valid_q <= 1'b1;
                      state_q     <= S_RESP;
                    end else begin
                      poll_q  <= poll_q + 10'd1;
                      gap_q   <= '0;
                      state_q <= S_GAP;
                    end
`else
                    gap_q   <= '0;
                    state_q <= S_GAP;
`endif
                  end else begin
                    addr_q  <= ADDR_W;
                    state_q <= S_RD_W;
                    if (m_rdata == ST_OVF)       ovf_q <= 1'b1;
                    else if (m_rdata != ST_IDLE) err_q <= 1'b1;
                  end
                end
                S_RD_W: begin
                  w_q     <= m_rdata;
                  addr_q  <= ADDR_L;
                  state_q <= S_RD_L;
                end
                default: begin
                  rsp_w_q     <= w_q;
                  rsp_ones_q  <= m_rdata;
                  rsp_ovf_q   <= ovf_q;
                  rsp_err_q   <= err_q;
                  rsp_valid_q <= 1'b1;
                  state_q     <= S_RESP;
                end
              endcase
            end
          endcase
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ack        = ack_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_w      = rsp_w_q;
  assign rsp_ones   = rsp_ones_q;
  assign rsp_ovf    = rsp_ovf_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = busy_q;
  assign m_saddress = addr_q;
  assign m_swr      = swr_q;
  assign m_srd      = srd_q;
  assign m_wdata    = wdata_q;

endmodule

// File: tb/tb_gpioemu_mul_sched.sv
// tb/tb_gpioemu_mul_sched.sv - directed scoreboard bench with a multiplier peripheral model and bus monitor
module tb_gpioemu_mul_sched;

  localparam int NREQ = 4;
  localparam int IDW  = 3;
  localparam int POLL_GAP = 4;
`ifdef MUL_TIMEOUT_EN
  localparam int POLL_LIMIT = 5;
`endif

  typedef struct packed { logic wr; logic [15:0] addr; logic [31:0] data; } acc_t;
  typedef struct packed { logic [IDW-1:0] id; logic [31:0] w; logic [31:0] ones; logic ovf; logic err; } rsp_t;

  logic                clk = 1'b0;
  logic                n_reset;
  logic [NREQ-1:0]     req;
  logic [NREQ*24-1:0]  op_a, op_b;
  logic [NREQ-1:0]     ack;
  logic                rsp_valid, rsp_ovf, rsp_err, busy, m_swr, m_srd;
  logic [IDW-1:0]      rsp_id;
  logic [31:0]         rsp_w, rsp_ones, m_wdata, m_rdata;
  logic [15:0]         m_saddress;

  gpioemu_mul_sched #(
    .NREQ(NREQ),
    .IDW(IDW),
`ifdef MUL_TIMEOUT_EN
    .POLL_LIMIT(POLL_LIMIT),
`endif
    .POLL_GAP(POLL_GAP)
  ) dut (
    .clk(clk), .n_reset(n_reset), .req(req), .op_a(op_a), .op_b(op_b),
    .ack(ack), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_w(rsp_w),
    .rsp_ones(rsp_ones), .rsp_ovf(rsp_ovf), .rsp_err(rsp_err), .busy(busy),
    .m_saddress(m_saddress), .m_swr(m_swr), .m_srd(m_srd),
    .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int proto_err = 0;

  acc_t            acc_log[$];
  acc_t            exp_acc[$];
  rsp_t            rsp_log[$];
  rsp_t            exp_q[$];
  logic [NREQ-1:0] ack_log[$];

  // Peripheral model: reacts to strobe rising edges, result ready after busy_polls busy replies.
  int          busy_polls = 0;
  int          busy_left = 0;
  logic        force_en = 1'b0;
  logic [31:0] force_val = '0;
  logic [23:0] pa1 = '0, pa2 = '0;
  logic        prev_swr = 1'b0, prev_srd = 1'b0;
  logic [47:0] prod;

  initial m_rdata = '0;

  always @(posedge clk) begin
    prod = 48'(pa1) * 48'(pa2);
    if (m_swr && !prev_swr) begin
      if (m_saddress == 16'h01D8) pa1 = m_wdata[23:0];
      if (m_saddress == 16'h01E0) begin pa2 = m_wdata[23:0]; busy_left = busy_polls; end
    end
    if (m_srd && !prev_srd) begin
      case (m_saddress)
        16'h01F8: begin
          if (force_en) m_rdata = force_val;
          else if (busy_left > 0) begin m_rdata = 32'd1; busy_left--; end
          else m_rdata = (prod[47:32] != 0) ? 32'd2 : 32'd0;
        end
        16'h01E8: m_rdata = (prod[47:32] != 0) ? prod[47:16] : prod[31:0];
        16'h01F0: m_rdata = 32'($countones(prod));
        default:  m_rdata = 32'hDEAD_BEEF;
      endcase
    end
    prev_swr = m_swr;
    prev_srd = m_srd;
  end

  // Bus/handshake monitor.
  logic        pend = 1'b0, prev_stb = 1'b0;
  logic [15:0] prev_addr = '0, hold_addr = '0;
  logic [31:0] prev_data = '0, hold_data = '0;

  always @(negedge clk) begin
    if (!n_reset) pend = 1'b0;
    else begin
      if (m_swr && m_srd) proto_err++;
      if (pend) begin
        if (m_swr || m_srd || m_saddress != hold_addr || m_wdata != hold_data) proto_err++;
        pend = 1'b0;
      end
      if (m_swr || m_srd) begin
        if (prev_stb || m_saddress != prev_addr || m_wdata != prev_data) proto_err++;
        if (!(m_saddress inside {16'h01D8, 16'h01E0, 16'h01E8, 16'h01F0, 16'h01F8})) proto_err++;
        acc_log.push_back('{wr: m_swr, addr: m_saddress, data: (m_swr ? m_wdata : 32'd0)});
        pend = 1'b1; hold_addr = m_saddress; hold_data = m_wdata;
      end
      if (ack != '0) begin
        if (!$onehot(ack)) proto_err++;
        ack_log.push_back(ack);
      end
      if (rsp_valid) rsp_log.push_back('{id: rsp_id, w: rsp_w, ones: rsp_ones, ovf: rsp_ovf, err: rsp_err});
    end
    prev_stb = m_swr | m_srd; prev_addr = m_saddress; prev_data = m_wdata;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic rsp_t mk(input int id, input logic [31:0] w, input logic [31:0] ones,
                              input logic ovf, input logic err);
    rsp_t r;
    r.id = IDW'(id); r.w = w; r.ones = ones; r.ovf = ovf; r.err = err;
    return r;
  endfunction

  task automatic wait_ack(input string tag, output logic [NREQ-1:0] a);
    int n = 0;
    while (ack_log.size() == 0 && n < 200) begin tick(); n++; end
    chk({tag, "_ack_seen"}, 64'(ack_log.size() != 0), 64'd1);
    a = (ack_log.size() != 0) ? ack_log.pop_front() : '0;
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    rsp_t got, exp;
    while (rsp_log.size() == 0 && n < 3000) begin tick(); n++; end
    chk({tag, "_rsp_seen"}, 64'(rsp_log.size() != 0), 64'd1);
    if (rsp_log.size() != 0 && exp_q.size() != 0) begin
      got = rsp_log.pop_front();
      exp = exp_q.pop_front();
      chk({tag, "_id"},   64'(got.id),   64'(exp.id));
      chk({tag, "_w"},    64'(got.w),    64'(exp.w));
      chk({tag, "_ones"}, 64'(got.ones), 64'(exp.ones));
      chk({tag, "_ovf"},  64'(got.ovf),  64'(exp.ovf));
      chk({tag, "_err"},  64'(got.err),  64'(exp.err));
    end
  endtask

  task automatic run_job(input int k, input logic [23:0] a, input logic [23:0] b,
                         input rsp_t exp, input string tag);
    logic [NREQ-1:0] got_ack;
    op_a[k*24 +: 24] = a;
    op_b[k*24 +: 24] = b;
    exp_q.push_back(exp);
    req[k] = 1'b1;
    wait_ack(tag, got_ack);
    chk({tag, "_ack"}, 64'(got_ack), 64'(NREQ'(1) << k));
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    req[k] = 1'b0;
    wait_rsp(tag);
  endtask

  initial begin
    logic [NREQ-1:0] fa;
    logic [47:0]     fp;
    int              found;
    n_reset = 1'b0; req = '0; op_a = '0; op_b = '0;
    repeat (3) tick();
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_busy_rspv", 64'({busy, rsp_valid}), 64'd0);
    chk("rst_strobes", 64'({m_swr, m_srd}), 64'd0);
    chk("rst_addr", 64'(m_saddress), 64'd0);
    chk("rst_wdata", 64'(m_wdata), 64'd0);
    chk("rst_rsp", 64'({rsp_id, rsp_ovf, rsp_err, rsp_w | rsp_ones}), 64'd0);
    n_reset = 1'b1;
    tick();

    // Single job: two busy polls, then done.
    acc_log.delete();
    busy_polls = 2;
    exp_acc.push_back('{wr: 1'b1, addr: 16'h01D8, data: 32'd3});
    exp_acc.push_back('{wr: 1'b1, addr: 16'h01E0, data: 32'd5});
    repeat (3) exp_acc.push_back('{wr: 1'b0, addr: 16'h01F8, data: 32'd0});
    exp_acc.push_back('{wr: 1'b0, addr: 16'h01E8, data: 32'd0});
    exp_acc.push_back('{wr: 1'b0, addr: 16'h01F0, data: 32'd0});
    run_job(0, 24'd3, 24'd5, mk(0, 32'd15, 32'd4, 1'b0, 1'b0), "single");
    chk("single_busy_in_resp", 64'(busy), 64'd1);
    tick();
    chk("single_busy_after", 64'(busy), 64'd0);
    chk("single_rsp_hold", 64'(rsp_w), 64'd15);
    chk("single_acc_count", 64'(acc_log.size()), 64'd7);
    for (int i = 0; i < 7; i++)
      if (i < acc_log.size()) chk("single_acc", 64'(acc_log[i]), 64'(exp_acc[i]));

    busy_polls = 0;
    run_job(1, 24'h7FFFFF, 24'h7FFFFF, mk(1, 32'h3FFFFF00, 32'd23, 1'b1, 1'b0), "ovf");

    force_en = 1'b1; force_val = 32'd3;
    run_job(2, 24'd2, 24'd3, mk(2, 32'd6, 32'd2, 1'b0, 1'b1), "badst");
    force_en = 1'b0;

    run_job(3, 24'd9, 24'd9, mk(3, 32'd81, 32'd3, 1'b0, 1'b0), "wrap");

    // Fairness: all requesters held, pointer back at 0.
    busy_polls = 1;
    for (int k = 0; k < NREQ; k++) begin
      op_a[k*24 +: 24] = 24'(16 + k);
      op_b[k*24 +: 24] = 24'(32 + k);
    end
    req = '1;
    for (int i = 0; i < 8; i++) begin
      fp = 48'(16 + i % 4) * 48'(32 + i % 4);
      exp_q.push_back(mk(i % 4, fp[31:0], 32'($countones(fp)), 1'b0, 1'b0));
      wait_ack("fair", fa);
      chk("fair_ack_order", 64'(fa), 64'(NREQ'(1) << (i % 4)));
      wait_rsp("fair");
    end
    req = '0;
    repeat (3) tick();
    chk("proto_clean", 64'(proto_err), 64'd0);

    // Reset in the middle of a polling job.
    busy_polls = 1000;
    acc_log.delete();
    req[0] = 1'b1; op_a[23:0] = 24'd7; op_b[23:0] = 24'd7;
    wait_ack("rstjob", fa);
    req[0] = 1'b0;
    found = 0;
    for (int n = 0; n < 200 && found == 0; n++) begin
      if (acc_log.size() != 0 && acc_log[acc_log.size()-1].addr == 16'h01F8) found = 1;
      else tick();
    end
    chk("rstjob_polling", 64'(found), 64'd1);
    tick(); tick();
    #2 n_reset = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_bus", 64'({m_swr, m_srd, m_saddress}), 64'd0);
    chk("midrst_rsp_w", 64'(rsp_w), 64'd0);
    acc_log.delete(); rsp_log.delete(); ack_log.delete(); exp_q.delete();
    busy_polls = 0;
    req[2] = 1'b1;
    tick(); tick();
    n_reset = 1'b1;
    run_job(2, 24'h11, 24'd2, mk(2, 32'h22, 32'd2, 1'b0, 1'b0), "postrst");
    if (acc_log.size() != 0) chk("postrst_first_acc", 64'(acc_log[0]), 64'({1'b1, 16'h01D8, 32'h11}));
    else chk("postrst_first_acc_seen", 64'd0, 64'd1);

`ifdef MUL_TIMEOUT_EN
    begin : tmo
      int n_poll, n_rd;
      n_poll = 0; n_rd = 0;
      busy_polls = 1000;
      acc_log.delete();
      run_job(0, 24'd4, 24'd4, mk(0, 32'd0, 32'd0, 1'b0, 1'b1), "tmo");
      foreach (acc_log[i]) begin
        if (acc_log[i].addr == 16'h01F8) n_poll++;
        if (acc_log[i].addr == 16'h01E8 || acc_log[i].addr == 16'h01F0) n_rd++;
      end
      chk("tmo_polls", 64'(n_poll), 64'(POLL_LIMIT));
      chk("tmo_no_result_reads", 64'(n_rd), 64'd0);
    end
`endif

    repeat (5) tick();
    chk("no_stray_ack", 64'(ack_log.size()), 64'd0);
    chk("no_stray_rsp", 64'(rsp_log.size()), 64'd0);
    chk("proto_final", 64'(proto_err), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
